sync_fifo_ctrl: RTL and testbench
=================================

Name: sync_fifo_ctrl

Overview:
Single-clock, parametrised circular-buffer FIFO. It is the successor to the shifting dual-clock FIFO used in the image capture path.
- Read/write pointers with explicit wrap, so there is no per-pop data shift.
- Valid/ready-style push/pop handshake, occupancy count, and programmable almost-full/almost-empty thresholds.
- Sits between the pixel/line capture logic and downstream packers, all in one clock domain.

Parameters:
- FIFO_SIZE, 8: depth in words; any integer >= 2, not restricted to powers of 2.
- DATA_WIDTH, 32: word width in bits.
- ALMOST_FULL_LEVEL, FIFO_SIZE-2: almost_full asserts when count >= this value.
- ALMOST_EMPTY_LEVEL, 2: almost_empty asserts when count <= this value.
- Derived, not overridable: CW = $clog2(FIFO_SIZE+1) (count width) and PW = $clog2(FIFO_SIZE) (pointer width).

Ports:
- clock  in  1  sole clock; all logic on its rising edge.
- clear_n  in  1  reset, synchronous, active-low.
- enable  in  1  when low, push and pop are ignored and all state is held.
- push  in  1  write request.
- in_data  in  DATA_WIDTH  write data; sampled when a push is accepted.
- push_ready  out  1  equals ~full; combinational from registered state.
- pop  in  1  read request.
- out_data  out  DATA_WIDTH  registered read data.
- out_valid  out  1  one-cycle pulse marking out_data as fresh.
- count  out  CW  current occupancy, 0..FIFO_SIZE.
- full  out  1  count == FIFO_SIZE.
- empty  out  1  count == 0.
- almost_full  out  1  count >= ALMOST_FULL_LEVEL.
- almost_empty  out  1  count <= ALMOST_EMPTY_LEVEL.
- pushed_last  out  1  one-cycle pulse: an accepted push made the FIFO full.
- popped_last  out  1  one-cycle pulse: an accepted pop made the FIFO empty.

Behaviour:
- Reset (clear_n == 0 at a clock edge):
  - wr_ptr = rd_ptr = 0, count = 0, out_data = 0.
  - out_valid = pushed_last = popped_last = 0.
  - Resulting flags: empty = 1, full = 0, push_ready = 1, almost_empty = 1, almost_full = 0.
  - Reset overrides push/pop in the same cycle, including mid-burst.
  - Storage array contents are not cleared; they are unobservable after reset.
- Handshake acceptance:
  - push_acc = enable & push & (~full | pop_acc).
  - pop_acc = enable & pop & ~empty.
- Accepted push: mem[wr_ptr] <= in_data; wr_ptr <= (wr_ptr == FIFO_SIZE-1) ? 0 : wr_ptr+1.
- Accepted pop:
  - out_data <= mem[rd_ptr]; out_valid <= 1 in the next cycle, so read latency is 1 clock.
  - rd_ptr wraps the same way as wr_ptr.
- No pop accepted: out_valid <= 0 and out_data holds its last value.
- count next value: count + push_acc - pop_acc. It never leaves 0..FIFO_SIZE.
- Full with push and pop in the same cycle: both accepted; the read uses the old rd_ptr slot; count stays FIFO_SIZE.
- Empty with push and pop in the same cycle: pop rejected (no fall-through); push accepted; count becomes 1.
- Push while full without pop: dropped; no state change.
- Pop while empty: out_valid stays 0; out_data unchanged.
- pushed_last <= push_acc & ~pop_acc & (count == FIFO_SIZE-1).
- popped_last <= pop_acc & ~push_acc & (count == 1).
- All flags are derived from the registered count, so they are valid in the cycle after the event.

Optional Feature:
- Macro: SYNC_FIFO_ERROR_FLAGS_EN.
- Defined: two extra outputs, overflow and underflow (1 bit each, sticky).
  - overflow sets when enable & push & ~push_acc.
  - underflow sets when enable & pop & empty.
  - Both clear only on clear_n == 0.
  - Adds a 16-bit saturating drop_count output that counts rejected pushes and saturates at 16'hFFFF.
- Undefined: these ports and their logic are absent. Rejected requests are silently ignored as above.

Test Plan:
- Reset then 8 consecutive pushes of 0x11..0x88 (FIFO_SIZE=8) -> count 0..8, full=1 after the 8th, pushed_last pulses exactly once in the cycle after the 8th push, push_ready=0.
- Full FIFO, push 0x99 alone -> dropped, count stays 8; then 8 pops -> out_data 0x11..0x88 in order, one clock after each pop, each with out_valid=1; popped_last pulses after the last pop; empty=1.
- Wrap: 5 pushes, 5 pops, 7 pushes (0xA1..0xA7), 7 pops -> data order preserved across the pointer wrap at index 7->0.
- Simultaneous push+pop:
  - at full: count stays 8, out_data = oldest word, new word appended;
  - at empty: pop ignored (out_valid=0), count becomes 1.
- Thresholds with ALMOST_FULL_LEVEL=6, ALMOST_EMPTY_LEVEL=2: almost_full rises at count 6; almost_empty falls at count 3. enable=0 during push/pop -> no change. clear_n=0 mid-burst -> count=0, out_data=0 next cycle.
- With SYNC_FIFO_ERROR_FLAGS_EN: 3 pushes when full -> overflow=1, drop_count=3; pop when empty -> underflow=1; both cleared by reset.

Source files
------------

// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock circular-buffer FIFO with wrap-around pointers,
// push/pop handshake, occupancy count and almost-full/almost-empty flags.
// Optional build macro SYNC_FIFO_ERROR_FLAGS_EN adds sticky overflow/underflow
// outputs and a saturating 16-bit drop_count of rejected pushes.
module sync_fifo_ctrl #(
  parameter int FIFO_SIZE          = 8,
  parameter int DATA_WIDTH         = 32,
  parameter int ALMOST_FULL_LEVEL  = FIFO_SIZE - 2,
  parameter int ALMOST_EMPTY_LEVEL = 2,
  localparam int CW = $clog2(FIFO_SIZE + 1),
  localparam int PW = $clog2(FIFO_SIZE)
) (
  input  logic                  clock,
  input  logic                  clear_n,
  input  logic                  enable,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
  output logic [15:0]           drop_count,
`endif
  output logic                  pushed_last,
  output logic                  popped_last
);

  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(FIFO_SIZE - 1);
  localparam logic [CW-1:0] AF_CNT   = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(ALMOST_EMPTY_LEVEL);
  localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_SIZE - 1);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_SIZE];

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;
  logic                  pushed_last_q, pushed_last_d;
  logic                  popped_last_q, popped_last_d;
  logic                  push_acc, pop_acc;

  // Flags come straight off the registered count.
  assign full         = (count_q == FULL_CNT);
  assign empty        = (count_q == '0);
  assign push_ready   = ~full;
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign pushed_last  = pushed_last_q;
  assign popped_last  = popped_last_q;

  // Handshake acceptance; a full FIFO still takes a push when a pop frees a slot.
  always_comb begin
    pop_acc  = enable & pop & ~empty;
    push_acc = enable & push & (~full | pop_acc);
  end

  // Next-state for pointers, count, read data and event pulses.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    out_data_d    = out_data_q;
    out_valid_d   = 1'b0;
    pushed_last_d = push_acc & ~pop_acc & (count_q == LAST_CNT);
    popped_last_d = pop_acc & ~push_acc & (count_q == CW'(1));
    if (push_acc)
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + PW'(1);
    if (pop_acc) begin
      rd_ptr_d    = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + PW'(1);
      out_data_d  = mem_q[rd_ptr_q];
      out_valid_d = 1'b1;
    end
    if (push_acc && !pop_acc)
      count_d = count_q + CW'(1);
    else if (pop_acc && !push_acc)
      count_d = count_q - CW'(1);
  end

  // Control state; clear_n wins over any same-cycle push/pop.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      pushed_last_q <= 1'b0;
      popped_last_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      out_data_q    <= out_data_d;
      out_valid_q   <= out_valid_d;
      pushed_last_q <= pushed_last_d;
      popped_last_q <= popped_last_d;
    end
  end

  // Storage array is never cleared; stale words are unreachable after reset.
  always_ff @(posedge clock) begin
    if (clear_n && push_acc)
      mem_q[wr_ptr_q] <= in_data;
  end

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
  logic [15:0] drop_count_q, drop_count_d;

  assign overflow   = overflow_q;
  assign underflow  = underflow_q;
  assign drop_count = drop_count_q;

  // Sticky error flags and saturating count of rejected pushes.
  always_comb begin
    overflow_d   = overflow_q | (enable & push & ~push_acc);
    underflow_d  = underflow_q | (enable & pop & empty);
    drop_count_d = drop_count_q;
    if (enable && push && !push_acc && drop_count_q != 16'hFFFF)
      drop_count_d = drop_count_q + 16'd1;
  end

  // Error state clears only on reset.
  always_ff @(posedge clock) begin
    if (!clear_n) begin
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      drop_count_q <= '0;
    end else begin
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      drop_count_q <= drop_count_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Directed bench for sync_fifo_ctrl (FIFO_SIZE=8, AF=6, AE=2).
module tb_sync_fifo_ctrl;
  localparam int DW = 32;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          clear_n, enable, push, pop;
  logic [DW-1:0] in_data;
  logic          push_ready, out_valid, full, empty, almost_full, almost_empty;
  logic          pushed_last, popped_last;
  logic [DW-1:0] out_data;
  logic [CW-1:0] count;
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
  logic          overflow, underflow;
  logic [15:0]   drop_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sync_fifo_ctrl #(.FIFO_SIZE(8), .DATA_WIDTH(DW), .ALMOST_FULL_LEVEL(6),
                   .ALMOST_EMPTY_LEVEL(2)) dut (
    .clock(clock), .clear_n(clear_n), .enable(enable),
    .push(push), .in_data(in_data), .push_ready(push_ready),
    .pop(pop), .out_data(out_data), .out_valid(out_valid),
    .count(count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    .overflow(overflow), .underflow(underflow), .drop_count(drop_count),
`endif
    .pushed_last(pushed_last), .popped_last(popped_last)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_push(input logic [31:0] d);
    push = 1'b1; pop = 1'b0; in_data = d;
    step();
    push = 1'b0;
  endtask

  task automatic do_pop_chk(input string tag, input logic [31:0] d);
    pop = 1'b1; push = 1'b0;
    step();
    pop = 1'b0;
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_vld"}, {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    clear_n = 1'b0; enable = 1'b1; push = 1'b0; pop = 1'b0; in_data = '0;
    step(); step();
    clear_n = 1'b1;

    // reset state
    chk("rst_count", {28'd0, count}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_ready", {31'd0, push_ready}, 32'd1);
    chk("rst_ae", {31'd0, almost_empty}, 32'd1);
    chk("rst_af", {31'd0, almost_full}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);

    // fill with 0x11..0x88, tracking thresholds and the pushed_last pulse
    for (int i = 0; i < 8; i++) begin
      do_push(32'((i + 1) * 'h11));
      chk("fill_count", {28'd0, count}, 32'(i + 1));
      chk("fill_plast", {31'd0, pushed_last}, (i == 7) ? 32'd1 : 32'd0);
      chk("fill_af", {31'd0, almost_full}, (i + 1 >= 6) ? 32'd1 : 32'd0);
      chk("fill_ae", {31'd0, almost_empty}, (i + 1 <= 2) ? 32'd1 : 32'd0);
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_ready", {31'd0, push_ready}, 32'd0);

    // push while full is dropped
    do_push(32'h99);
    chk("drop_count", {28'd0, count}, 32'd8);
    chk("drop_plast", {31'd0, pushed_last}, 32'd0);

    // drain in order
    for (int i = 0; i < 8; i++) begin
      do_pop_chk("drain", 32'((i + 1) * 'h11));
      chk("drain_count", {28'd0, count}, 32'(7 - i));
      chk("drain_poplast", {31'd0, popped_last}, (i == 7) ? 32'd1 : 32'd0);
    end
    chk("drain_empty", {31'd0, empty}, 32'd1);

    // pop while empty: no valid, data held
    pop = 1'b1; step(); pop = 1'b0;
    chk("uflow_vld", {31'd0, out_valid}, 32'd0);
    chk("uflow_data", out_data, 32'h88);
    chk("uflow_poplast", {31'd0, popped_last}, 32'd0);

    // wrap: 5 in/out, then 7 in/out across index 7->0
    for (int i = 1; i <= 5; i++) do_push(32'(i));
    for (int i = 1; i <= 5; i++) do_pop_chk("wrap5", 32'(i));
    for (int i = 1; i <= 7; i++) do_push(32'('hA0 + i));
    chk("wrap_count", {28'd0, count}, 32'd7);
    for (int i = 1; i <= 7; i++) do_pop_chk("wrap7", 32'('hA0 + i));

    // simultaneous push+pop at full
    for (int i = 0; i < 8; i++) do_push(32'('hB0 + i));
    push = 1'b1; pop = 1'b1; in_data = 32'hC0;
    step();
    push = 1'b0; pop = 1'b0;
    chk("pp_full_count", {28'd0, count}, 32'd8);
    chk("pp_full_data", out_data, 32'hB0);
    chk("pp_full_vld", {31'd0, out_valid}, 32'd1);
    chk("pp_full_plast", {31'd0, pushed_last}, 32'd0);
    for (int i = 1; i < 8; i++) do_pop_chk("pp_rest", 32'('hB0 + i));
    do_pop_chk("pp_new", 32'hC0);

    // simultaneous push+pop at empty: no fall-through
    push = 1'b1; pop = 1'b1; in_data = 32'hD0;
    step();
    push = 1'b0; pop = 1'b0;
    chk("pp_empty_vld", {31'd0, out_valid}, 32'd0);
    chk("pp_empty_count", {28'd0, count}, 32'd1);
    chk("pp_empty_data", out_data, 32'hC0);

    // enable low holds everything
    enable = 1'b0; push = 1'b1; pop = 1'b1; in_data = 32'hEE;
    step();
    push = 1'b0; pop = 1'b0; enable = 1'b1;
    chk("en_count", {28'd0, count}, 32'd1);
    chk("en_vld", {31'd0, out_valid}, 32'd0);
    do_pop_chk("en_data", 32'hD0);

    // reset mid-burst
    do_push(32'h1); do_push(32'h2);
    push = 1'b1; pop = 1'b1; in_data = 32'h3; clear_n = 1'b0;
    step();
    push = 1'b0; pop = 1'b0; clear_n = 1'b1;
    chk("mid_rst_count", {28'd0, count}, 32'd0);
    chk("mid_rst_data", out_data, 32'd0);
    chk("mid_rst_vld", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    do_push(32'hE0);
    do_pop_chk("post_rst", 32'hE0);

`ifdef SYNC_FIFO_ERROR_FLAGS_EN
    chk("err_ovf0", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) do_push(32'(i));
    for (int i = 0; i < 3; i++) do_push(32'hFF);
    chk("err_ovf", {31'd0, overflow}, 32'd1);
    chk("err_drops", {16'd0, drop_count}, 32'd3);
    chk("err_udf0", {31'd0, underflow}, 32'd0);
    for (int i = 0; i < 8; i++) do_pop_chk("err_drain", 32'(i));
    pop = 1'b1; step(); pop = 1'b0;
    chk("err_udf", {31'd0, underflow}, 32'd1);
    clear_n = 1'b0; step(); clear_n = 1'b1;
    chk("err_rst_ovf", {31'd0, overflow}, 32'd0);
    chk("err_rst_udf", {31'd0, underflow}, 32'd0);
    chk("err_rst_drops", {16'd0, drop_count}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
